// File: rtl/button_conditioner_if.sv
// Push-button event bundle: raw pin in, debounced level and single-cycle events out.
interface button_conditioner_if;
  logic button;
  logic btn_level;
  logic btn_pulse;
  logic btn_long;
  logic btn_repeat;
  logic btn_release;

  modport master (
    input  button,
    output btn_level,
    output btn_pulse,
    output btn_long,
    output btn_repeat,
    output btn_release
  );

  modport slave (
    output button,
    input  btn_level,
    input  btn_pulse,
    input  btn_long,
    input  btn_repeat,
    input  btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces the board push-button, emitting press, long-press,
// auto-repeat and release pulses in the clk_g domain.
module button_conditioner #(
  parameter int unsigned DB_CYCLES     = 200000,
  parameter int unsigned LONG_CYCLES   = 20000000,
  parameter int unsigned REPEAT_CYCLES = 4000000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic                 clk_g,
  input  logic                 rst,
  button_conditioner_if.master bus
);

  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = '0;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_nxt;
  state_t           ret_state, ret_state_nxt;
  state_t           cnt_state;
  logic             sync_ff1, sync_in;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             count_en;
  logic             level_nxt, pulse_nxt, long_nxt, repeat_nxt, release_nxt;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync_in  <= 1'b0;
    end else begin
      sync_ff1 <= bus.button;
      sync_in  <= sync_ff1;
    end
  end

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ret_state       <= PRESSED;
      db_cnt          <= ZERO;
      hold_cnt        <= ZERO;
      bus.btn_level   <= 1'b0;
      bus.btn_pulse   <= 1'b0;
      bus.btn_long    <= 1'b0;
      bus.btn_repeat  <= 1'b0;
      bus.btn_release <= 1'b0;
    end else begin
      state           <= state_nxt;
      ret_state       <= ret_state_nxt;
      db_cnt          <= db_cnt_nxt;
      hold_cnt        <= hold_cnt_nxt;
      bus.btn_level   <= level_nxt;
      bus.btn_pulse   <= pulse_nxt;
      bus.btn_long    <= long_nxt;
      bus.btn_repeat  <= repeat_nxt;
      bus.btn_release <= release_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    db_cnt_nxt    = db_cnt;
    hold_cnt_nxt  = hold_cnt;
    level_nxt     = bus.btn_level;
    pulse_nxt     = 1'b0;
    long_nxt      = 1'b0;
    repeat_nxt    = 1'b0;
    release_nxt   = 1'b0;
    count_en      = 1'b0;
    cnt_state     = state;

    case (state)
      IDLE: begin
        if (sync_in) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync_in) begin
          state_nxt  = IDLE;
          db_cnt_nxt = ZERO;
        end else if (db_cnt == DB_MAX) begin
          state_nxt    = PRESSED;
          pulse_nxt    = 1'b1;
          level_nxt    = 1'b1;
          hold_cnt_nxt = ONE;
        end else begin
          db_cnt_nxt = db_cnt + ONE;
        end
      end
      PRESSED, HELD: begin
        if (!sync_in) begin
          state_nxt     = RELEASE_WAIT;
          ret_state_nxt = state;
          db_cnt_nxt    = ONE;
        end else begin
          count_en = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (sync_in) begin
          // A bounce resumes the return state, and this high cycle counts toward hold_cnt
          state_nxt = ret_state;
          cnt_state = ret_state;
          count_en  = 1'b1;
        end else if (db_cnt == DB_MAX) begin
          state_nxt    = IDLE;
          release_nxt  = 1'b1;
          level_nxt    = 1'b0;
          hold_cnt_nxt = ZERO;
          db_cnt_nxt   = ZERO;
        end else begin
          db_cnt_nxt = db_cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Long-press / auto-repeat timing while the button reads high
    if (count_en) begin
      if (cnt_state == PRESSED && hold_cnt == LONG_MAX) begin
        state_nxt    = HELD;
        long_nxt     = 1'b1;
        hold_cnt_nxt = ONE;
      end else if (cnt_state == HELD && hold_cnt == REP_MAX) begin
        repeat_nxt   = 1'b1;
        hold_cnt_nxt = ONE;
      end else begin
        hold_cnt_nxt = hold_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB=4, LONG=20, REPEAT=5.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  button_conditioner_if bus();

  button_conditioner #(
    .DB_CYCLES    (4),
    .LONG_CYCLES  (20),
    .REPEAT_CYCLES(5),
    .CNT_W        (25)
  ) dut (
    .clk_g(clk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int n_pulse, n_long, n_rep, n_rel;
  int last_pulse, last_long, first_rep, last_rep;
  int hot;
  int k, p, r, s, p2, k3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_pulse = 0; n_long = 0; n_rep = 0; n_rel = 0;
    last_pulse = -1; last_long = -1; first_rep = -1; last_rep = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic until_edge(input int e);
    while (edge_n < e) @(negedge clk);
    #1;
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Per-cycle event log; edge_n is the edge that produced the current outputs
  always @(negedge clk) begin
    hot = int'(bus.btn_pulse) + int'(bus.btn_long) + int'(bus.btn_repeat) + int'(bus.btn_release);
    check("onehot", 32'(hot > 1), 32'(0));
    if (bus.btn_pulse)   begin n_pulse++; last_pulse = edge_n; end
    if (bus.btn_long)    begin n_long++;  last_long  = edge_n; end
    if (bus.btn_repeat)  begin if (n_rep == 0) first_rep = edge_n; n_rep++; last_rep = edge_n; end
    if (bus.btn_release) n_rel++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.button = 1'b0;
    clr();
    step(3);
    check("rst_outputs", 32'({bus.btn_level, bus.btn_pulse, bus.btn_long, bus.btn_repeat, bus.btn_release}), 32'(0));
    rst = 1'b0;
    step(2);

    // Clean press
    clr();
    bus.button = 1'b1;
    k = edge_n + 1;
    until_edge(k + 5);
    check("press_early_pulse", 32'(n_pulse), 32'(0));
    check("press_early_level", 32'(bus.btn_level), 32'(0));
    until_edge(k + 6);
    check("press_pulse", 32'(bus.btn_pulse), 32'(1));
    check("press_level", 32'(bus.btn_level), 32'(1));
    p = k + 6;
    until_edge(p + 1);
    check("press_pulse_width", 32'(bus.btn_pulse), 32'(0));

    // Long hold with auto-repeat
    until_edge(p + 50);
    check("hold_pulses", 32'(n_pulse), 32'(1));
    check("hold_long_cnt", 32'(n_long), 32'(1));
    check("hold_long_time", 32'(last_long - p), 32'(20));
    check("hold_rep_cnt", 32'(n_rep), 32'(6));
    check("hold_rep_first", 32'(first_rep - p), 32'(25));
    check("hold_rep_last", 32'(last_rep - p), 32'(50));
    check("hold_level", 32'(bus.btn_level), 32'(1));

    // Release from HELD
    clr();
    bus.button = 1'b0;
    r = edge_n + 1;
    until_edge(r + 5);
    check("rel_early_level", 32'(bus.btn_level), 32'(1));
    check("rel_early_cnt", 32'(n_rel), 32'(0));
    until_edge(r + 6);
    check("rel_pulse", 32'(bus.btn_release), 32'(1));
    check("rel_level", 32'(bus.btn_level), 32'(0));
    step(3);
    check("rel_cnt", 32'(n_rel), 32'(1));
    check("rel_no_repeat", 32'(n_rep), 32'(0));

    // Bouncy press: short highs, including one just under the debounce length
    clr();
    for (int i = 0; i < 3; i++) begin
      bus.button = 1'b1; step(2);
      bus.button = 1'b0; step(2);
    end
    bus.button = 1'b1; step(3);
    bus.button = 1'b0; step(2);
    check("bounce_no_pulse", 32'(n_pulse), 32'(0));
    check("bounce_level", 32'(bus.btn_level), 32'(0));
    bus.button = 1'b1;
    s = edge_n + 1;
    until_edge(s + 5);
    check("bounce_early", 32'(n_pulse), 32'(0));
    until_edge(s + 6);
    check("bounce_pulse", 32'(bus.btn_pulse), 32'(1));
    p2 = s + 6;

    // Two-cycle release bounce while PRESSED at hold_cnt=10
    until_edge(p2 + 7);
    bus.button = 1'b0;
    step(2);
    bus.button = 1'b1;
    until_edge(p2 + 21);
    check("rb_long_not_nominal", 32'(n_long), 32'(0));
    until_edge(p2 + 22);
    check("rb_long_late", 32'(bus.btn_long), 32'(1));
    check("rb_no_release", 32'(n_rel), 32'(0));
    check("rb_pulses", 32'(n_pulse), 32'(1));
    check("rb_level", 32'(bus.btn_level), 32'(1));

    // Async reset while HELD, button kept high
    until_edge(p2 + 24);
    clr();
    #2;
    rst = 1'b1;
    #1;
    check("arst_outputs", 32'({bus.btn_level, bus.btn_pulse, bus.btn_long, bus.btn_repeat, bus.btn_release}), 32'(0));
    step(2);
    rst = 1'b0;
    k3 = edge_n + 1;
    until_edge(k3 + 5);
    check("arst_early", 32'(n_pulse), 32'(0));
    until_edge(k3 + 6);
    check("arst_pulse", 32'(bus.btn_pulse), 32'(1));
    check("arst_level", 32'(bus.btn_level), 32'(1));
    check("arst_no_release", 32'(n_rel), 32'(0));
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage that turns the raw board push-button into clean, single-cycle control events for the memory read/write controller, all in the `clk_g` domain. It synchronises the pin and debounces press and release. It emits a one-cycle press pulse, which drives the controller's `button` input, plus long-press, auto-repeat and release pulses. It sits between the board pin and the memory controller inside the memory top level.

## Interface

- `DB_CYCLES`, default 200000: consecutive stable cycles needed to accept a press or release (10 ms at 20 MHz `clk_g`); legal range ≥1.
- `LONG_CYCLES`, default 20000000: cycles held in PRESSED before a long press is declared (1 s).
- `REPEAT_CYCLES`, default 4000000: auto-repeat period in HELD (200 ms); legal range ≥1.
- `CNT_W`, default 25: width of each internal counter; must hold max(`DB_CYCLES`, `LONG_CYCLES`, `REPEAT_CYCLES`).
- `clk_g` input 1: the single clock (PLL output).
- `rst` input 1: reset, asynchronous, active-high.
- `button` input 1: raw pin, asynchronous, active-high, bouncy.
- `btn_level` output 1: debounced button level.
- `btn_pulse` output 1: one-cycle pulse on accepted press; drives the controller's `button`.
- `btn_long` output 1: one-cycle pulse when a press becomes a long press.
- `btn_repeat` output 1: one-cycle pulse every `REPEAT_CYCLES` while in HELD.
- `btn_release` output 1: one-cycle pulse on accepted release.

## Operation

- Reset (async assert, released on clock): state IDLE, both synchroniser flops 0, all counters 0, all outputs 0.
- Synchroniser: two flops. `sync_in` is the second flop's output. The FSM looks only at `sync_in`.
- Counters: `db_cnt` (debounce), `hold_cnt` (long/repeat). Both are `CNT_W` bits and never wrap; each is compared and cleared explicitly.
- IDLE: on `sync_in`=1, go to PRESS_WAIT and set `db_cnt`=1.
- PRESS_WAIT:
  - On `sync_in`=0, go to IDLE with no event.
  - On `sync_in`=1 and `db_cnt`<`DB_CYCLES`, increment `db_cnt`.
  - On `sync_in`=1 and `db_cnt`=`DB_CYCLES`, go to PRESSED. Pulse `btn_pulse`, set `btn_level`=1, set `hold_cnt`=1.
- PRESSED:
  - On `sync_in`=1, increment `hold_cnt`.
  - When `hold_cnt`=`LONG_CYCLES`, go to HELD, pulse `btn_long`, set `hold_cnt`=1.
  - On `sync_in`=0, go to RELEASE_WAIT with `db_cnt`=1 and return-state=PRESSED. `hold_cnt` is frozen.
- HELD:
  - On `sync_in`=1, increment `hold_cnt`.
  - When `hold_cnt`=`REPEAT_CYCLES`, pulse `btn_repeat` and set `hold_cnt`=1.
  - On `sync_in`=0, go to RELEASE_WAIT with return-state=HELD.
- RELEASE_WAIT:
  - On `sync_in`=0, count `db_cnt`. At `DB_CYCLES`, go to IDLE, pulse `btn_release`, set `btn_level`=0, clear `hold_cnt`.
  - On `sync_in`=1 (a bounce), return to the return-state. `hold_cnt` resumes from its frozen value and no event is emitted.
- `btn_level` is 1 in PRESSED, HELD and RELEASE_WAIT, and 0 otherwise.
- At most one of the pulse outputs is high in any cycle.
- `btn_long` and `btn_repeat` never fire in the same cycle. The first repeat comes `REPEAT_CYCLES` after `btn_long`.
- Reset mid-operation: return to IDLE immediately with no release pulse. A button still held after reset requires a full new debounce before `btn_pulse`.

## Timing

- All outputs are registered and change only on `clk_g` rising edges, except the async clear.
- Press latency: let edge k be the one at which the first synchroniser flop captures 1 and stays 1. Then `btn_pulse` is high for exactly the cycle after edge k+`DB_CYCLES`+2.
- `btn_level` rises in that same cycle.
- Release latency: `btn_release` is high for exactly the cycle after edge r+`DB_CYCLES`+2, where r is the edge at which the first flop captures 0 and stays 0.
- `btn_level` falls in that same cycle.
- Long press: `btn_long` comes `LONG_CYCLES` cycles after `btn_pulse` when there are no bounces.
- Repeats: `btn_repeat` pulses every `REPEAT_CYCLES` cycles thereafter.
- Glitches shorter than `DB_CYCLES` cycles, in either direction, produce no event.

## Test plan

Bench parameters: `DB_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=5.

- Clean press: `button` goes 1 at edge 10 and is held → `btn_pulse` is high only in the cycle after edge 16, and `btn_level`=1 from then on.
- Bouncy press: `button` toggles 1/0 with 2-cycle highs, then holds steady → no pulse during the bounce, and exactly one `btn_pulse` at steady-start+6.
- Long hold: hold for 50 cycles after `btn_pulse` → `btn_long` at +20, then `btn_repeat` at +25, +30, …, +50. Never two pulses in one cycle.
- Release bounce: in PRESSED at `hold_cnt`=10, `button` goes 0 for 2 cycles then back to 1 → no `btn_release`, and `btn_long` arrives 2 cycles later than nominal (the low cycles are not counted).
- Release: drop `button` and hold at 0 → `btn_release` at r+6, `btn_level`=0, and the next press needs a full debounce.
- Async reset in HELD: assert `rst` mid-cycle → all outputs 0 immediately and no `btn_release`. Deassert with `button` still 1 → `btn_pulse` after 6 edges.
